// File: rtl/bin2bcd_seq_feeder.sv
// bin2bcd_seq_feeder
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding
// the 16-bit input register of the 4-digit seven-segment display interface.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bin_in    binary value, sampled only on the edge a start is accepted
//   start     conversion request, level-sampled, accepted only when idle
//   busy      high from the accepting edge until the return to idle
//   data_out  packed BCD, digit3 in [15:12] .. digit0 in [3:0]
//   we        one-cycle strobe, high exactly when data_out is new
//   ovf       last converted value exceeded 9999 (updated with data_out)
//
// Build option:
//   BCD_SAT_EN  when defined, an overflowing result saturates data_out to
//               16'h9999; otherwise data_out wraps (value mod 10000).
//
// state   | meaning
// S_IDLE  | waiting for start; data_out/ovf hold last result
// S_SHIFT | one add-3 + shift per cycle, BIN_W cycles
// S_DONE  | one cycle; result registered with we on the leaving edge

module bin2bcd_seq_feeder #(
   parameter int BIN_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             start,
   output logic             busy,
   output logic [15:0]      data_out,
   output logic             we,
   output logic             ovf
);

   localparam int SW = 20 + BIN_W;
   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   sh_q, sh_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     data_q, data_d;
   logic            ovf_q, ovf_d;
   logic            we_q, we_d;
   logic            busy_q, busy_d;

   logic [SW-1:0]   adj;
   logic [19:0]     bcd;
   logic            res_ovf;

   // All five BCD digits corrected in parallel before the shift.
   always_comb begin
      adj = sh_q;
      for (int i = 0; i < 5; i++) begin
         if (sh_q[BIN_W+4*i +: 4] >= 4'd5) begin
            adj[BIN_W+4*i +: 4] = sh_q[BIN_W+4*i +: 4] + 4'd3;
         end
      end
   end

   assign bcd     = sh_q[SW-1:BIN_W];
   assign res_ovf = |bcd[19:16];

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      we_d    = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sh_d    = {20'd0, bin_in};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sh_d  = adj << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(BIN_W - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Result lands with we; busy drops on the same edge so a new
            // start can be accepted one cycle later (BIN_W+2 spacing).
`ifdef BCD_SAT_EN
            data_d = res_ovf ? 16'h9999 : bcd[15:0];
`else
            data_d = bcd[15:0];
`endif
            ovf_d   = res_ovf;
            we_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         data_q  <= 16'h0000;
         ovf_q   <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign data_out = data_q;
   assign we       = we_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq_feeder.sv
module tb_bin2bcd_seq_feeder;

   localparam int BIN_W = 14;

   logic             clk = 1'b0;
   logic             rst;
   logic [BIN_W-1:0] bin_in;
   logic             start;
   logic             busy;
   logic [15:0]      data_out;
   logic             we;
   logic             ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bin2bcd_seq_feeder #(.BIN_W(BIN_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bin_in   (bin_in),
      .start    (start),
      .busy     (busy),
      .data_out (data_out),
      .we       (we),
      .ovf      (ovf)
   );

   typedef struct {
      int          bin;
      logic [15:0] exp_data;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_out(input logic [15:0] wrap, input logic o);
`ifdef BCD_SAT_EN
      return o ? 16'h9999 : wrap;
`else
      return wrap;
`endif
   endfunction

   // Independent decimal model for the streaming test (values < 10000).
   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'(v % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   function automatic int sval(input int c);
      return 1000 + 37 * c;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge where we
   // is high (busy already low), so back-to-back calls give minimum spacing.
   task automatic conv(input int v, input logic [15:0] ed, input logic eo);
      bin_in = BIN_W'(v);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bin_in = ~BIN_W'(v);
      chk("busy_after_accept", {15'd0, busy}, 16'd1);
      chk("we_after_accept", {15'd0, we}, 16'd0);
      for (int n = 1; n <= BIN_W + 1; n++) begin
         @(negedge clk);
         bin_in = BIN_W'(n * 131);
         if (n == BIN_W + 1) begin
            chk("we_pulse", {15'd0, we}, 16'd1);
            chk("data_out", data_out, ed);
            chk("ovf", {15'd0, ovf}, {15'd0, eo});
            chk("busy_done", {15'd0, busy}, 16'd0);
         end else if (we) begin
            chk("we_early", {15'd0, we}, 16'd0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{1234,  16'h1234, 1'b0};
      vecs[1] = '{0,     16'h0000, 1'b0};
      vecs[2] = '{9999,  16'h9999, 1'b0};
      vecs[3] = '{12345, 16'h2345, 1'b1};
      vecs[4] = '{10000, 16'h0000, 1'b1};
      vecs[5] = '{16383, 16'h6383, 1'b1};
      vecs[6] = '{1,     16'h0001, 1'b0};
      vecs[7] = '{5,     16'h0005, 1'b0};
      vecs[8] = '{4096,  16'h4096, 1'b0};
      vecs[9] = '{8765,  16'h8765, 1'b0};

      rst    = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_data", data_out, 16'h0000);
         chk("idle_flags", {13'd0, we, busy, ovf}, 16'd0);
      end

      // Table vectors, each started the cycle busy drops.
      for (int i = 0; i < 10; i++) begin
         conv(vecs[i].bin, exp_out(vecs[i].exp_data, vecs[i].exp_ovf), vecs[i].exp_ovf);
      end

      // Hold: we must drop, data/ovf must persist.
      @(negedge clk);
      chk("we_single", {15'd0, we}, 16'd0);
      chk("hold_data", data_out, 16'h8765);

      // start held high, bin_in changing each cycle: accepts every 16 cycles.
      for (int c = 0; c < 64; c++) begin
         bin_in = BIN_W'(sval(c));
         start  = 1'b1;
         @(negedge clk);
         if ((c % 16) == 15) begin
            chk("stream_we", {15'd0, we}, 16'd1);
            chk("stream_data", data_out, to_bcd(sval(c - 15)));
            chk("stream_busy", {15'd0, busy}, 16'd0);
         end else begin
            chk("stream_we_low", {15'd0, we}, 16'd0);
            chk("stream_busy_hi", {15'd0, busy}, 16'd1);
         end
      end
      start = 1'b0;

      // Reset 5 cycles into a conversion.
      bin_in = BIN_W'(4321);
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_data", data_out, 16'h0000);
      chk("rst_flags", {13'd0, we, busy, ovf}, 16'd0);
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (we || busy) begin
            chk("rst_no_we", {14'd0, we, busy}, 16'd0);
         end
      end
      chk("rst_quiet_data", data_out, 16'h0000);
      conv(4321, 16'h4321, 1'b0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
